router_sync_n: RTL and testbench

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_sync_n.sv | 108 ++++++++++
 tb/tb_router_sync_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header destination, steers FIFO write enables and full
// status, and raises per-channel soft-reset pulses when a valid channel sits unread too long.
module router_sync_n #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);

  localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  // One extra bit so NUM_CH == 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W:0] NumChW = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_vld_q;
  logic              addr_err_q;
  logic [ADDR_W-1:0] sel;
  logic              din_legal;
  logic              sel_vld;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] idle;
  logic [NUM_CH-1:0] soft_reset_d, soft_reset_q;
  logic [CntW-1:0]   cnt_d [NUM_CH];
  logic [CntW-1:0]   cnt_q [NUM_CH];

  assign din_legal = ({1'b0, data_in} < NumChW);

  // Header cycle bypasses the register so a concurrent write is routed immediately.
  always_comb begin
    sel     = addr_q;
    sel_vld = addr_vld_q;
    if (detect_add) begin
      sel     = data_in;
      sel_vld = din_legal;
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh[i] = sel_vld && (sel == ADDR_W'(i));
    end
  end

  assign write_enb  = write_enb_reg ? sel_oh : '0;
  assign fifo_full  = |(full & sel_oh);
  assign vld_out    = ~empty;
  assign idle       = vld_out & ~read_enb;
  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= detect_add && !din_legal;
      if (detect_add) begin
        addr_q     <= data_in;
        addr_vld_q <= din_legal;
      end
    end
  end

  always_comb begin
    soft_reset_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (idle[i]) begin
        if (cnt_q[i] == CntMax) begin
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      soft_reset_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Self-checking bench for router_sync_n: routing, address errors and per-channel timeouts.
module tb_router_sync_n;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;

  logic              clock = 1'b0;
  logic              resetn;
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [NUM_CH-1:0] exp_q [$];
  logic [NUM_CH-1:0] exp;

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb     (read_enb),
    .empty        (empty),
    .full         (full),
    .vld_out      (vld_out),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b0;
    read_enb = '0; empty = '1; full = '0;
    #3;
    n_checks++;
    if (soft_reset !== 3'b000) begin
      n_errors++; $display("FAIL reset_soft_reset: got %b want 000", soft_reset);
    end
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err);
    end
    write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (write_enb !== 3'b000) begin
      n_errors++; $display("FAIL reset_write_enb_noaddr: got %b want 000", write_enb);
    end
    detect_add = 1'b1; data_in = 2'd2;
    #1;
    n_checks++;
    if (write_enb !== 3'b100) begin
      n_errors++; $display("FAIL reset_bypass: got %b want 100", write_enb);
    end
    detect_add = 1'b0; write_enb_reg = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_routing();
    for (int a = 0; a < NUM_CH; a++) begin
      // Header and write in the same cycle route to the new address.
      detect_add = 1'b1; data_in = ADDR_W'(a); write_enb_reg = 1'b1; full = '0;
      #1;
      n_checks++;
      if (write_enb !== 3'(1 << a)) begin
        n_errors++; $display("FAIL route_bypass[%0d]: got %b want %b", a, write_enb, 3'(1 << a));
      end
      tick();
      detect_add = 1'b0;
      #1;
      n_checks++;
      if (write_enb !== 3'(1 << a) || addr_err !== 1'b0) begin
        n_errors++;
        $display("FAIL route_held[%0d]: got we=%b err=%b want we=%b err=0",
                 a, write_enb, addr_err, 3'(1 << a));
      end
      full = 3'(1 << a); write_enb_reg = 1'b0;
      #1;
      n_checks++;
      if (fifo_full !== 1'b1) begin
        n_errors++; $display("FAIL full_sel[%0d]: got %b want 1", a, fifo_full);
      end
      full = ~3'(1 << a);
      #1;
      n_checks++;
      if (fifo_full !== 1'b0) begin
        n_errors++; $display("FAIL full_other[%0d]: got %b want 0", a, fifo_full);
      end
      tick();
    end
    full = '0;
  endtask

  task automatic test_bad_addr();
    detect_add = 1'b1; data_in = 2'b11; write_enb_reg = 1'b1; full = '1;
    #1;
    n_checks++;
    if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      n_errors++; $display("FAIL bad_route: got we=%b ff=%b want we=000 ff=0", write_enb, fifo_full);
    end
    tick();
    detect_add = 1'b0;
    #1;
    n_checks++;
    if (addr_err !== 1'b1 || write_enb !== 3'b000 || fifo_full !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_err: got err=%b we=%b ff=%b want 1 000 0", addr_err, write_enb, fifo_full);
    end
    tick();
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_errors++; $display("FAIL bad_err_width: got %b want 0", addr_err);
    end
    write_enb_reg = 1'b0; full = '0;
    empty = 3'b101;
    #1;
    n_checks++;
    if (vld_out !== 3'b010) begin
      n_errors++; $display("FAIL vld_out: got %b want 010", vld_out);
    end
    empty = '1;
    tick();
  endtask

  task automatic test_timeout();
    for (int k = 1; k <= 2 * TIMEOUT + 1; k++) exp_q.push_back((k % TIMEOUT == 0) ? 3'b001 : 3'b000);
    empty = 3'b110; read_enb = '0;
    for (int k = 1; exp_q.size() > 0; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (soft_reset !== exp) begin
        n_errors++; $display("FAIL timeout edge %0d: got %b want %b", k, soft_reset, exp);
      end
    end
    empty = '1;
    tick();
  endtask

  task automatic test_partial();
    for (int k = 1; k <= 2 * TIMEOUT + 1; k++) exp_q.push_back((k == 2 * TIMEOUT) ? 3'b001 : 3'b000);
    empty = 3'b110;
    for (int k = 1; exp_q.size() > 0; k++) begin
      read_enb = (k == TIMEOUT) ? 3'b001 : 3'b000;
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (soft_reset !== exp) begin
        n_errors++; $display("FAIL partial edge %0d: got %b want %b", k, soft_reset, exp);
      end
    end
    read_enb = '0; empty = '1;
    tick();
  endtask

  task automatic test_reset_mid();
    detect_add = 1'b1; data_in = 2'd2;
    tick();
    detect_add = 1'b0;
    empty = 3'b110;
    for (int k = 0; k < 20; k++) tick();
    resetn = 1'b0;
    #2;
    write_enb_reg = 1'b1;
    #1;
    n_checks++;
    if (soft_reset !== 3'b000 || write_enb !== 3'b000) begin
      n_errors++;
      $display("FAIL midreset_clear: got sr=%b we=%b want 000 000", soft_reset, write_enb);
    end
    resetn = 1'b1; write_enb_reg = 1'b0;
    for (int k = 1; k <= TIMEOUT + 1; k++) exp_q.push_back((k == TIMEOUT) ? 3'b001 : 3'b000);
    for (int k = 1; exp_q.size() > 0; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (soft_reset !== exp) begin
        n_errors++; $display("FAIL midreset edge %0d: got %b want %b", k, soft_reset, exp);
      end
    end
    empty = '1;
    tick();
  endtask

  task automatic test_all_channels();
    for (int k = 1; k <= TIMEOUT + 1; k++) exp_q.push_back((k == TIMEOUT) ? 3'b111 : 3'b000);
    empty = 3'b000; read_enb = '0;
    for (int k = 1; exp_q.size() > 0; k++) begin
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (soft_reset !== exp) begin
        n_errors++; $display("FAIL all_ch edge %0d: got %b want %b", k, soft_reset, exp);
      end
    end
    empty = '1;
    tick();
  endtask

  initial begin
    test_reset();
    test_routing();
    test_bad_addr();
    test_timeout();
    test_partial();
    test_reset_mid();
    test_all_channels();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
